// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage handshake, data-memory response and register-file write bus of wb_stage.
// The o_fwd_* bypass signals exist only when WB_FWD_EN is defined.
interface wb_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 32,
    parameter int REG_FILE_ADDR  = $clog2(REG_FILE_DEPTH)
);
    logic                     i_MEM_valid;
    logic                     o_MEM_ready;
    logic                     i_MEM_wb_en;
    logic [REG_FILE_ADDR-1:0] i_MEM_dst_reg;
    logic [1:0]               i_MEM_result_sel;
    logic [DATA_WIDTH-1:0]    i_MEM_alu_result;
    logic [DATA_WIDTH-1:0]    i_MEM_pc_plus4;
    logic [2:0]               i_MEM_funct3;
    logic [1:0]               i_MEM_addr_lo;
    logic                     i_dmem_rvalid;
    logic [DATA_WIDTH-1:0]    i_dmem_rdata;
    logic [DATA_WIDTH-1:0]    o_WB_result;
    logic [REG_FILE_ADDR-1:0] o_WB_addr;
    logic                     o_ctrl_WB_en;
    logic                     o_stall;
    logic [31:0]              o_retire_count;
    logic [15:0]              o_load_wait_cycles;
`ifdef WB_FWD_EN
    logic                     o_fwd_valid;
    logic [REG_FILE_ADDR-1:0] o_fwd_addr;
    logic [DATA_WIDTH-1:0]    o_fwd_data;
`endif

    modport master (
        output i_MEM_valid, i_MEM_wb_en, i_MEM_dst_reg, i_MEM_result_sel,
               i_MEM_alu_result, i_MEM_pc_plus4, i_MEM_funct3, i_MEM_addr_lo,
               i_dmem_rvalid, i_dmem_rdata,
        input  o_MEM_ready, o_WB_result, o_WB_addr, o_ctrl_WB_en, o_stall,
               o_retire_count, o_load_wait_cycles
`ifdef WB_FWD_EN
        , input o_fwd_valid, o_fwd_addr, o_fwd_data
`endif
    );

    modport slave (
        input  i_MEM_valid, i_MEM_wb_en, i_MEM_dst_reg, i_MEM_result_sel,
               i_MEM_alu_result, i_MEM_pc_plus4, i_MEM_funct3, i_MEM_addr_lo,
               i_dmem_rvalid, i_dmem_rdata,
        output o_MEM_ready, o_WB_result, o_WB_addr, o_ctrl_WB_en, o_stall,
               o_retire_count, o_load_wait_cycles
`ifdef WB_FWD_EN
        , output o_fwd_valid, o_fwd_addr, o_fwd_data
`endif
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: picks the byte/halfword lane and sign- or zero-extends it.
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    output logic [DATA_WIDTH-1:0] result
);
    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_lane[gi] = rdata[8*gi +: 8];
    end

    assign byte_val = byte_lane[addr_lo];
    // Halfword lane is chosen by addr_lo[1] only; misaligned bit 0 is ignored.
    assign half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_LB:   result = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
            F3_LH:   result = {{(DATA_WIDTH-16){half_val[15]}}, half_val};
            F3_LBU:  result = {{(DATA_WIDTH-8){1'b0}}, byte_val};
            F3_LHU:  result = {{(DATA_WIDTH-16){1'b0}}, half_val};
            F3_LW:   result = rdata;
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// RISC-V write-back stage: result select, register-file write pulse, load wait and counters.
// Optional combinational bypass outputs are enabled by defining WB_FWD_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 32,
    parameter int REG_FILE_ADDR  = $clog2(REG_FILE_DEPTH)
) (
    input  logic       i_clk,
    input  logic       i_reset,
    wb_stage_if.slave  bus
);
    wb_state_e                state_reg, state_next;
    logic                     ready, stall;
    logic                     accept, nonload_fire, load_done, wr_fire, wr_en;
    logic [DATA_WIDTH-1:0]    sel_value, aligned, wr_data;
    logic [REG_FILE_ADDR-1:0] wr_addr;

    logic                     ld_wb_en_reg;
    logic [REG_FILE_ADDR-1:0] ld_dst_reg;
    logic [2:0]               ld_funct3_reg;
    logic [1:0]               ld_addr_lo_reg;

    logic [DATA_WIDTH-1:0]    result_reg;
    logic [REG_FILE_ADDR-1:0] addr_reg;
    logic                     en_reg;
    logic [31:0]              retire_reg;
    logic [15:0]              load_wait_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (accept && bus.i_MEM_result_sel == RES_LOAD) state_next = WAIT_LOAD;
            WAIT_LOAD: if (bus.i_dmem_rvalid) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_reg == IDLE);
        stall = (state_reg == WAIT_LOAD);
    end

    assign accept       = bus.i_MEM_valid & ready;
    assign nonload_fire = accept & (bus.i_MEM_result_sel != RES_LOAD);
    assign load_done    = stall & bus.i_dmem_rvalid;
    assign wr_fire      = nonload_fire | load_done;

    // Select value 11 falls through to the ALU result.
    assign sel_value = (bus.i_MEM_result_sel == RES_PC4) ? bus.i_MEM_pc_plus4 : bus.i_MEM_alu_result;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .rdata   (bus.i_dmem_rdata),
        .funct3  (ld_funct3_reg),
        .addr_lo (ld_addr_lo_reg),
        .result  (aligned)
    );

    assign wr_data = nonload_fire ? sel_value : aligned;
    assign wr_addr = nonload_fire ? bus.i_MEM_dst_reg : ld_dst_reg;
    assign wr_en   = nonload_fire ? (bus.i_MEM_wb_en && bus.i_MEM_dst_reg != '0)
                                  : (load_done && ld_wb_en_reg && ld_dst_reg != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ld_wb_en_reg   <= 1'b0;
            ld_dst_reg     <= '0;
            ld_funct3_reg  <= '0;
            ld_addr_lo_reg <= '0;
        end else if (accept) begin
            ld_wb_en_reg   <= bus.i_MEM_wb_en;
            ld_dst_reg     <= bus.i_MEM_dst_reg;
            ld_funct3_reg  <= bus.i_MEM_funct3;
            ld_addr_lo_reg <= bus.i_MEM_addr_lo;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            result_reg    <= '0;
            addr_reg      <= '0;
            en_reg        <= 1'b0;
            retire_reg    <= '0;
            load_wait_reg <= '0;
        end else begin
            en_reg <= wr_en;
            if (wr_fire) begin
                result_reg <= wr_data;
                addr_reg   <= wr_addr;
                retire_reg <= retire_reg + 32'd1;
            end
            if (stall && !bus.i_dmem_rvalid && load_wait_reg != 16'hFFFF)
                load_wait_reg <= load_wait_reg + 16'd1;
        end
    end

    assign bus.o_MEM_ready        = ready;
    assign bus.o_stall            = stall;
    assign bus.o_WB_result        = result_reg;
    assign bus.o_WB_addr          = addr_reg;
    assign bus.o_ctrl_WB_en       = en_reg;
    assign bus.o_retire_count     = retire_reg;
    assign bus.o_load_wait_cycles = load_wait_reg;

`ifdef WB_FWD_EN
    assign bus.o_fwd_valid = wr_en;
    assign bus.o_fwd_addr  = wr_en ? wr_addr : '0;
    assign bus.o_fwd_data  = wr_en ? wr_data : '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writes, a negedge monitor checks pulses.
module tb_wb_stage;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if bus ();

    wb_stage dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] retire;
    } exp_t;

    exp_t        sb_q[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_retire = 0;
    logic [15:0] exp_lw = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    always @(negedge clk) begin
        if (bus.o_ctrl_WB_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got x%0d = %h, expected no write", bus.o_WB_addr, bus.o_WB_result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("write x%0d = %h (retired %0d)", bus.o_WB_addr, bus.o_WB_result, bus.o_retire_count);
                check("wb_addr", 32'(bus.o_WB_addr), 32'(e.addr));
                check("wb_result", bus.o_WB_result, e.data);
                check("retire_count", bus.o_retire_count, e.retire);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_op(input logic en, input logic [4:0] dst, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc4);
        bus.i_MEM_valid      = 1'b1;
        bus.i_MEM_wb_en      = en;
        bus.i_MEM_dst_reg    = dst;
        bus.i_MEM_result_sel = sel;
        bus.i_MEM_alu_result = alu;
        bus.i_MEM_pc_plus4   = pc4;
    endtask

    task automatic push_write(input logic en, input logic [4:0] dst, input logic [31:0] data);
        exp_t e;
        exp_retire++;
        if (en && dst != 5'd0) begin
            e.addr = dst; e.data = data; e.retire = exp_retire;
            sb_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge where the write is visible.
    task automatic alu_op(input logic en, input logic [4:0] dst, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] exp_data);
        set_op(en, dst, sel, alu, pc4);
        push_write(en, dst, exp_data);
        @(negedge clk);
        bus.i_MEM_valid = 1'b0;
        check("retire_after_op", bus.o_retire_count, exp_retire);
        if (!(en && dst != 5'd0)) check("no_pulse", 32'(bus.o_ctrl_WB_en), 32'd0);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] dst,
                           input logic [31:0] rd, input int dly, input logic [31:0] exp_data);
        int st;
        set_op(1'b1, dst, 2'b01, 32'hBAD0_BAD0, 32'hBAD1_BAD1);
        bus.i_MEM_funct3  = f3;
        bus.i_MEM_addr_lo = lo;
        @(negedge clk);
        bus.i_MEM_valid = 1'b0;
        st = 0;
        for (int i = 0; i < dly; i++) begin
            if (bus.o_stall === 1'b1 && bus.o_MEM_ready === 1'b0) st++;
            if (i == dly - 1) begin
                bus.i_dmem_rvalid = 1'b1;
                bus.i_dmem_rdata  = rd;
                push_write(1'b1, dst, exp_data);
            end
            @(negedge clk);
        end
        bus.i_dmem_rvalid = 1'b0;
        bus.i_dmem_rdata  = 32'h0;
        exp_lw = exp_lw + 16'(dly - 1);
        check("stall_cycles", 32'(st), 32'(dly));
        check("load_wait_cycles", 32'(bus.o_load_wait_cycles), 32'(exp_lw));
        check("ready_after_load", 32'(bus.o_MEM_ready), 32'd1);
    endtask

    initial begin
        bus.i_MEM_valid = 0; bus.i_MEM_wb_en = 0; bus.i_MEM_dst_reg = 0;
        bus.i_MEM_result_sel = 0; bus.i_MEM_alu_result = 0; bus.i_MEM_pc_plus4 = 0;
        bus.i_MEM_funct3 = 0; bus.i_MEM_addr_lo = 0; bus.i_dmem_rvalid = 0; bus.i_dmem_rdata = 0;
        repeat (2) @(negedge clk);

        check("rst_result", bus.o_WB_result, 32'h0);
        check("rst_addr", 32'(bus.o_WB_addr), 32'h0);
        check("rst_en", 32'(bus.o_ctrl_WB_en), 32'h0);
        check("rst_retire", bus.o_retire_count, 32'h0);
        check("rst_load_wait", 32'(bus.o_load_wait_cycles), 32'h0);
        check("rst_ready", 32'(bus.o_MEM_ready), 32'h1);
        check("rst_stall", 32'(bus.o_stall), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        alu_op(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 32'h1234_5678);

        do_load(F3_LB,  2'd2, 5'd6,  32'h0080_0000, 3, 32'hFFFF_FF80);
        do_load(F3_LBU, 2'd2, 5'd7,  32'h0080_0000, 1, 32'h0000_0080);
        do_load(F3_LH,  2'd3, 5'd8,  32'h8001_0000, 2, 32'hFFFF_8001);
        do_load(F3_LHU, 2'd3, 5'd9,  32'h8001_0000, 1, 32'h0000_8001);
        do_load(F3_LW,  2'd1, 5'd10, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        do_load(3'b110, 2'd3, 5'd11, 32'h8000_0000, 1, 32'h8000_0000);
        do_load(F3_LB,  2'd0, 5'd12, 32'h0000_007F, 1, 32'h0000_007F);
        do_load(F3_LH,  2'd0, 5'd13, 32'h0000_FFFE, 1, 32'hFFFF_FFFE);

        alu_op(1'b1, 5'd0,  2'b10, 32'h0,         32'h0000_0104, 32'h0000_0104);
        alu_op(1'b1, 5'd14, 2'b10, 32'h5555_5555, 32'h0000_0104, 32'h0000_0104);
        alu_op(1'b1, 5'd15, 2'b11, 32'hCAFE_F00D, 32'h0000_0200, 32'hCAFE_F00D);
        alu_op(1'b0, 5'd16, 2'b00, 32'h1111_1111, 32'h0,         32'h1111_1111);

        // rvalid while idle must not write
        bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.i_dmem_rvalid = 1'b0;
        check("idle_rvalid_no_write", 32'(bus.o_ctrl_WB_en), 32'd0);
        check("idle_rvalid_retire", bus.o_retire_count, exp_retire);

        // back-to-back ALU ops to x1..x4
        for (int k = 1; k <= 4; k++) begin
            set_op(1'b1, 5'(k), 2'b00, 32'hA000_0000 + 32'(k), 32'h0);
            push_write(1'b1, 5'(k), 32'hA000_0000 + 32'(k));
`ifdef WB_FWD_EN
            #1;
            check("fwd_valid", 32'(bus.o_fwd_valid), 32'd1);
            check("fwd_addr", 32'(bus.o_fwd_addr), 32'(k));
            check("fwd_data", bus.o_fwd_data, 32'hA000_0000 + 32'(k));
`endif
            @(negedge clk);
            check("b2b_pulse", 32'(bus.o_ctrl_WB_en), 32'd1);
        end
        bus.i_MEM_valid = 1'b0;
`ifdef WB_FWD_EN
        #1;
        check("fwd_idle_valid", 32'(bus.o_fwd_valid), 32'd0);
        check("fwd_idle_data", bus.o_fwd_data, 32'd0);
`endif

        // reset while a load is outstanding; stale rvalid afterwards
        set_op(1'b1, 5'd20, 2'b01, 32'h0, 32'h0);
        bus.i_MEM_funct3 = F3_LW; bus.i_MEM_addr_lo = 2'd0;
        @(negedge clk);
        bus.i_MEM_valid = 1'b0;
        @(negedge clk);
        check("stall_before_reset", 32'(bus.o_stall), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'h9999_9999;
        @(negedge clk);
        bus.i_dmem_rvalid = 1'b0;
        exp_retire = 0; exp_lw = 0;
        check("rst_wait_no_write", 32'(bus.o_ctrl_WB_en), 32'd0);
        check("rst_wait_ready", 32'(bus.o_MEM_ready), 32'd1);
        check("rst_wait_stall", 32'(bus.o_stall), 32'd0);
        check("rst_wait_retire", bus.o_retire_count, 32'd0);
        check("rst_wait_load_wait", 32'(bus.o_load_wait_cycles), 32'd0);

        alu_op(1'b1, 5'd9, 2'b00, 32'h0BAD_CAFE, 32'h0, 32'h0BAD_CAFE);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage RISC-V pipeline and the writer side of the decode-stage register file write port. It accepts retiring instructions from the memory stage and selects the result: ALU result, aligned and extended load data, or PC+4. It then drives the register file write address, data and enable as registered one-cycle pulses. It stalls upstream while a load response is outstanding, and keeps retire and load-wait counters.

## Interface
Parameters:
- DATA_WIDTH, 32, register/result width
- REG_FILE_DEPTH, 32, number of architectural registers
- REG_FILE_ADDR, $clog2(REG_FILE_DEPTH), derived; not to be overridden

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_MEM_valid  in  1  memory stage presents an instruction
- o_MEM_ready  out  1  stage can accept; high only in IDLE
- i_MEM_wb_en  in  1  instruction writes a destination register
- i_MEM_dst_reg  in  REG_FILE_ADDR  destination register
- i_MEM_result_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU
- i_MEM_alu_result  in  DATA_WIDTH  ALU result
- i_MEM_pc_plus4  in  DATA_WIDTH  link value
- i_MEM_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- i_MEM_addr_lo  in  2  load byte offset
- i_dmem_rvalid  in  1  data memory read response valid
- i_dmem_rdata  in  DATA_WIDTH  data memory read word
- o_WB_result  out  DATA_WIDTH  register file write data
- o_WB_addr  out  REG_FILE_ADDR  register file write address
- o_ctrl_WB_en  out  1  register file write enable, one-cycle pulse
- o_stall  out  1  load outstanding; high in WAIT_LOAD
- o_retire_count  out  32  instructions retired, wraps
- o_load_wait_cycles  out  16  cycles spent in WAIT_LOAD, saturates at 16'hFFFF

## Operation
- FSM states are IDLE and WAIT_LOAD. Reset state is IDLE.
- Accept is i_MEM_valid & o_MEM_ready. The accepted instruction's fields are latched.
- Accepting a non-load in IDLE:
  - On the next edge, o_WB_result gets the selected value and o_WB_addr gets dst.
  - o_ctrl_WB_en = wb_en & (dst != 0) for that one cycle.
  - o_retire_count increments. The state stays IDLE.
- Accepting a load (sel=01) moves the state to WAIT_LOAD.
  - In WAIT_LOAD, o_MEM_ready=0 and o_stall=1.
  - Each WAIT_LOAD cycle without rvalid increments o_load_wait_cycles.
- WAIT_LOAD with i_dmem_rvalid=1:
  - The aligned result is registered with the write pulse on the next edge, as for a non-load.
  - The retire counter increments and the state returns to IDLE.
- Load alignment:
  - Byte loads take rdata[8*addr_lo +: 8]. Halfword loads take rdata[16*addr_lo[1] +: 16] and ignore addr_lo[0]. Word loads ignore addr_lo.
  - LB and LH sign-extend from the top bit of the extracted field. LBU and LHU zero-extend.
  - Undefined funct3 values (011, 110, 111) are treated as LW.
- Writes to x0 (dst==0) are never pulsed. The instruction still retires and the counter still increments.
- i_dmem_rvalid in IDLE is ignored.
- i_MEM_valid in WAIT_LOAD is not accepted. Upstream holds it until ready.

## Timing
- Reset values: o_WB_result=0, o_WB_addr=0, o_ctrl_WB_en=0, o_retire_count=0, o_load_wait_cycles=0. o_MEM_ready=1 and o_stall=0, since the state is IDLE.
- Non-load latency: 1 cycle from accept to the write pulse. Throughput is 1 per cycle; back-to-back accepts give back-to-back pulses.
- Load latency: 1 cycle after the rvalid cycle. The earliest rvalid is the cycle after accept, so the minimum load occupancy is 2 cycles.
- o_MEM_ready and o_stall are combinational from state only, with no input-to-output path.
- When rvalid arrives in WAIT_LOAD, the next accept can occur the cycle after.
- Reset mid-WAIT_LOAD:
  - The state returns to IDLE and the pending load is dropped without a write.
  - A stale rvalid after reset is ignored.
  - Both counters clear.
- If reset is asserted on the same edge as an accept, reset wins and the instruction is dropped.

## Configuration
- WB_FWD_EN: when defined, the block adds ports o_fwd_valid (1), o_fwd_addr (REG_FILE_ADDR) and o_fwd_data (DATA_WIDTH).
  - They are combinational and present the value that will be written on the next edge.
  - o_fwd_valid = wb_en & dst!=0 & (non-load accept | WAIT_LOAD & rvalid). This lets decode bypass without waiting for the register file.
  - When o_fwd_valid=0, o_fwd_addr and o_fwd_data are 0.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

## Structure
- Package wb_pkg holds:
  - result_sel_e (RES_ALU, RES_LOAD, RES_PC4)
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
  - wb_state_e (IDLE, WAIT_LOAD)
- Sub-module load_align: purely combinational, with inputs rdata, funct3 and addr_lo, and output the aligned, extended word. It is instantiated once.

## Test plan
- Reset, then accept ALU sel=00 with dst=5 and result 32'h1234_5678 -> next cycle WB_en=1, addr=5, result=32'h1234_5678, retire_count=1.
- LB with addr_lo=2, rdata=32'h00_80_00_00 and rvalid 3 cycles after accept -> stall high 3 cycles, load_wait_cycles=2, write data 32'hFFFF_FF80; LBU with the same inputs gives 32'h0000_0080.
- LH with addr_lo=3 and rdata=32'h8001_0000 -> result 32'hFFFF_8001; LHU gives 32'h0000_8001.
- PC+4 select (sel=10) with pc_plus4=32'h0000_0104 and dst=0 -> no WB_en pulse, retire_count increments.
- Load accepted, reset asserted in WAIT_LOAD, rvalid arrives the cycle after reset -> no write, state IDLE, ready=1, counters 0.
- With WB_FWD_EN, four back-to-back ALU ops to dst 1..4 -> fwd_valid high in each accept cycle with matching addr/data, and four consecutive WB_en pulses.
